gumnut_int_ctrl: RTL
====================

Name: gumnut_int_ctrl

Overview:
Interrupt controller sitting directly upstream of the Gumnut control unit. It collects up to 8 peripheral interrupt lines, synchronises them, latches edge and level events in a pending register, and applies a mask. It drives the control unit's int_req and consumes its one-cycle int_ack pulse. Software programs it as a slave on the Gumnut I/O port bus using inp/out.

Parameters:
N_SRC, 8, number of interrupt sources (1..8); bits at or above N_SRC read 0 and ignore writes.
BASE_ADDR, 8'hC0, port address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
int_src_i  in  N_SRC  raw asynchronous peripheral interrupt lines.
int_req  out  1  interrupt request to the control unit.
int_ack  in  1  one-cycle acknowledge from the control unit.
int_vec_o  out  3  index of the source captured at the last int_ack.
port_adr_i  in  8  I/O port address.
port_dat_i  in  8  write data.
port_dat_o  out  8  read data; valid while port_ack_o is high, otherwise 0.
port_we_i  in  1  write enable.
port_stb_i  in  1  strobe.
port_cyc_i  in  1  cycle.
port_ack_o  out  1  acknowledge.

Behaviour:
- Reset (rst=0, asynchronous): sync flops=0, prev=0, PENDING=0, MASK=0, EDGE=all 1s (edge mode), VEC=0, port_ack_o=0, port_dat_o=0. int_req=0 follows from PENDING=0.
- Synchroniser: each source passes through 2 flops, giving s. Edge detect uses s & ~prev, with prev registered each clock.
- Pending update, per bit i, every clock:
  - EDGE[i]=1: set on a rising edge of s; clear on int_ack when i is the selected source, or on a write-1-to-clear to PENDING. A set and a clear in the same cycle resolve to set.
  - EDGE[i]=0: PENDING[i] = s[i] each clock. Acks and W1C writes have no effect; the device must drop its line.
- int_req = |(PENDING & MASK), combinational from registers. A raw rising edge becomes visible on int_req after 3 clock edges.
- Priority: the lowest index in PENDING & MASK wins.
- int_ack with a winner: VEC <= winner index, and that bit is cleared if it is an edge source.
- int_ack with no winner (spurious): no state change.
- int_ack is sampled only on its own; it is never qualified by port activity.
- Register map (offset from BASE_ADDR):
  - 0 PENDING: read; write 1 to clear.
  - 1 MASK: read/write, 1 = enabled.
  - 2 EDGE: read/write, 1 = edge mode, 0 = level mode.
  - 3 STATUS: read {int_req, 4'b0, VEC}; writes ignored.
- Port handshake, two states (IDLE, ACK):
  - IDLE -> ACK when port_stb_i & port_cyc_i & address hit. Register writes commit on this same edge. port_dat_o is loaded with the read value on this edge.
  - ACK -> IDLE unconditionally next clock. port_ack_o=1 only in ACK, so a held strobe yields one ack every 2 cycles.
  - Address miss: no ack and no state change.
- Mode change: writing EDGE while a bit is pending leaves PENDING intact until the next update rule applies.
- Writing MASK=0 for a pending source drops int_req within the same cycle the write commits.

Optional Feature:
INT_CTRL_AUTO_MASK_EN.
- Defined: on int_ack with a winner, MASK[winner] is also cleared, so level sources cannot re-request before software re-enables them. A same-cycle MASK write takes priority over the auto-clear.
- Undefined: int_ack never modifies MASK.

Test Plan:
- Reset then read all four registers -> PENDING=00, MASK=00, EDGE=FF, STATUS=00, int_req=0.
- MASK=0x04, pulse int_src_i[2] for 1 cycle -> int_req=1 exactly 3 edges later; int_ack pulse -> VEC=2, PENDING=00, int_req=0 next cycle; STATUS reads 0x02.
- MASK=0xFF, raise sources 5 and 1 together -> first ack gives VEC=1 and PENDING=0x20; second ack gives VEC=5 and int_req=0.
- EDGE=0x00, hold int_src_i[3]=1, MASK=0x08, ack -> PENDING[3] stays 1, int_req stays 1 (no AUTO_MASK); with INT_CTRL_AUTO_MASK_EN -> MASK reads 0x00 and int_req=0.
- Edge on source 0 in the same cycle as a W1C write of 0x01 to PENDING -> PENDING[0]=1 (set wins); a spurious ack with MASK=0 leaves VEC unchanged.
- Hold port_stb_i/port_cyc_i at BASE_ADDR+1 for 6 cycles -> ack pulses on cycles 2, 4, 6; an address miss at BASE_ADDR+4 -> no ack.

Source files
------------

// File: rtl/gumnut_int_ctrl.sv
// Gumnut interrupt controller. It synchronises the source lines, keeps a pending/mask/edge
// register set on the I/O port bus, and drives int_req. Optional build macro: INT_CTRL_AUTO_MASK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a strobed cycle that hits the register window
// ST_ACK  | port_ack_o high for one cycle; read data is on port_dat_o
module gumnut_int_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hC0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] int_src_i,
    output logic             int_req,
    input  logic             int_ack,
    output logic [2:0]       int_vec_o,
    input  logic [7:0]       port_adr_i,
    input  logic [7:0]       port_dat_i,
    output logic [7:0]       port_dat_o,
    input  logic             port_we_i,
    input  logic             port_stb_i,
    input  logic             port_cyc_i,
    output logic             port_ack_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    bus_state_t       state_q, state_d;

    logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [2:0]       vec_q, vec_d;
    logic [7:0]       dat_q, dat_d;

    logic [7:0]       adr_off;
    logic             adr_hit;
    logic             bus_start;
    logic             wr_en;
    logic [N_SRC-1:0] wr_data;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] w1c;
    logic [2:0]       win_idx;
    logic             has_win;
    logic             ack_take;
    logic [7:0]       rd_data;

    function automatic logic [7:0] pad8(input logic [N_SRC-1:0] v);
        logic [7:0] r;
        r = '0;
        r[N_SRC-1:0] = v;
        return r;
    endfunction

    // Window offset wraps modulo 256, so any BASE_ADDR works without a wide compare.
    assign adr_off = port_adr_i - BASE_ADDR;
    assign adr_hit = (adr_off[7:2] == 6'd0);
    assign wr_data = port_dat_i[N_SRC-1:0];

    assign rise    = sync2_q & ~prev_q;
    assign masked  = pending_q & mask_q;
    assign has_win = |masked;
    assign ack_take = int_ack & has_win;

    assign int_req    = has_win;
    assign int_vec_o  = vec_q;
    assign port_dat_o = dat_q;

    always_comb begin
        state_d    = state_q;
        bus_start  = 1'b0;
        port_ack_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (port_stb_i && port_cyc_i && adr_hit) begin
                    bus_start = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                port_ack_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en = bus_start & port_we_i;

    always_comb begin
        win_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_take && (win_idx == 3'(i));
        end
    end

    assign w1c = (wr_en && adr_off[1:0] == 2'd0) ? wr_data : '0;

    // Edge bits: a new edge beats any clear in the same cycle. Level bits just mirror s.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (edge_q[i])
                pending_d[i] = rise[i] | (pending_q[i] & ~(ack_clr[i] | w1c[i]));
            else
                pending_d[i] = sync2_q[i];
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_en && adr_off[1:0] == 2'd1)
            mask_d = wr_data;
`ifdef INT_CTRL_AUTO_MASK_EN
        else
            mask_d = mask_q & ~ack_clr;
`endif
    end

    always_comb begin
        edge_d = edge_q;
        if (wr_en && adr_off[1:0] == 2'd2)
            edge_d = wr_data;
    end

    always_comb begin
        vec_d = vec_q;
        if (ack_take)
            vec_d = win_idx;
    end

    always_comb begin
        rd_data = 8'h00;
        case (adr_off[1:0])
            2'd0: rd_data = pad8(pending_q);
            2'd1: rd_data = pad8(mask_q);
            2'd2: rd_data = pad8(edge_q);
            2'd3: rd_data = {int_req, 4'b0000, vec_q};
            default: rd_data = 8'h00;
        endcase
    end

    // Read data is only held during the ack cycle and returns to 0 afterwards.
    assign dat_d = bus_start ? rd_data : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '1;
            vec_q     <= 3'd0;
            dat_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            sync1_q   <= int_src_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            vec_q     <= vec_d;
            dat_q     <= dat_d;
        end
    end

endmodule
